regfile_write_arbiter: RTL

- Shares the single register-file write port between two writeback requesters: A = ALU result, B = load result.
- Arbitrates round-robin with valid/ready handshakes and drives registered write_enable/write_address/write_data_in into the register file.
- Keeps a pending-write scoreboard (one bit per register) that issue logic sets and granted writes clear, so the decoder can stall on RAW hazards.

---
 rtl/regfile_write_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port, with a
// registered write stage and a per-register pending-write scoreboard.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_a_valid,
  input  logic [ADDR_WIDTH-1:0]      req_a_address,
  input  logic [DATA_WIDTH-1:0]      req_a_data,
  output logic                       req_a_ready,
  input  logic                       req_b_valid,
  input  logic [ADDR_WIDTH-1:0]      req_b_address,
  input  logic [DATA_WIDTH-1:0]      req_b_data,
  output logic                       req_b_ready,
  input  logic                       reserve_valid,
  input  logic [ADDR_WIDTH-1:0]      reserve_address,
  output logic [(2**ADDR_WIDTH)-1:0] pending,
  output logic                       write_enable,
  output logic [ADDR_WIDTH-1:0]      write_address,
  output logic [DATA_WIDTH-1:0]      write_data_in
);

  localparam int   NUM_REGS = 2**ADDR_WIDTH;
  localparam logic GRANT_A  = 1'b0;
  localparam logic GRANT_B  = 1'b1;

  logic                  last_grant_reg;
  logic                  write_enable_reg;
  logic [ADDR_WIDTH-1:0] write_address_reg;
  logic [DATA_WIDTH-1:0] write_data_reg;
  logic [NUM_REGS-1:0]   pending_reg;
  logic [NUM_REGS-1:0]   pending_next;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NUM_REGS-1:0]   clr_vec;

  logic                  grant_a;
  logic                  grant_b;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] win_address;
  logic [DATA_WIDTH-1:0] win_data;

  // Ready is a function of the valids and last_grant only; gating with reset
  // keeps both low while reset is held, whatever last_grant currently holds.
  always_comb begin
    grant_a     = reset && req_a_valid && (!req_b_valid || (last_grant_reg == GRANT_B));
    grant_b     = reset && req_b_valid && (!req_a_valid || (last_grant_reg == GRANT_A));
    transfer    = grant_a || grant_b;
    win_address = grant_a ? req_a_address : req_b_address;
    win_data    = grant_a ? req_a_data    : req_b_data;
  end

  assign req_a_ready = grant_a;
  assign req_b_ready = grant_b;

  // Register 0 never gets a set bit, so pending[0] stays at its reset value 0.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_score
      assign set_vec[gi] = (gi != 0) && reserve_valid &&
                           (reserve_address == ADDR_WIDTH'(gi));
      assign clr_vec[gi] = transfer && (win_address == ADDR_WIDTH'(gi));
    end
  endgenerate

  // A same-edge reservation outranks the clear: it belongs to a newer writer.
  assign pending_next = (pending_reg & ~clr_vec) | set_vec;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_reg    <= GRANT_B;
      write_enable_reg  <= 1'b0;
      write_address_reg <= '0;
      write_data_reg    <= '0;
      pending_reg       <= '0;
    end else begin
      if (req_a_valid && req_b_valid) begin
        last_grant_reg <= grant_a ? GRANT_A : GRANT_B;
      end
      write_enable_reg <= transfer && (win_address != '0);
      if (transfer) begin
        write_address_reg <= win_address;
        write_data_reg    <= win_data;
      end
      pending_reg <= pending_next;
    end
  end

  assign write_enable  = write_enable_reg;
  assign write_address = write_address_reg;
  assign write_data_in = write_data_reg;
  assign pending       = pending_reg;

endmodule
